pong_vga_renderer: RTL and testbench

Downstream consumer of the game state machine. Generates 640×480@60 VGA timing and draws the ball, both paddles and background onto a 12-bit RGB pixel stream. Ball and paddle coordinates are sampled once per frame into shadow registers so a frame never tears. A `frame_tick` pulse tells the state machine when to advance its physics by one frame step.

---
 rtl/pong_pkg.sv | 60 ++++++
 rtl/pong_vga_renderer_if.sv | 33 +++
 rtl/pong_vga_renderer_vga_timing.sv | 93 +++++++++
 rtl/pong_vga_renderer.sv | 167 ++++++++++++++++
 tb/tb_pong_vga_renderer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg
//   Shared constants and types for the Pong VGA renderer.
//   - VGA 640x480@60 timing (active/porch/sync widths, totals, sync windows)
//   - coordinate width (10 bits) and colour channel width (4 bits)
//   - rgb_t pixel type and the colour palette (WHITE, GREEN, RED, GREY, BLACK)
//   - in_span(): half-open range test done one bit wider than the
//     coordinates, so start+size can never wrap back into the screen.
//   NET_X_START/NET_X_END are only used when PONG_CENTER_LINE_EN is defined.
package pong_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 4;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_FP         = 16;
    localparam int VGA_H_SYNC       = 96;
    localparam int VGA_H_BP         = 48;
    localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_FP         = 10;
    localparam int VGA_V_SYNC       = 2;
    localparam int VGA_V_BP         = 33;
    localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    // Dashed centre net columns [start, end)
    localparam int NET_X_START = 318;
    localparam int NET_X_END   = 322;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam rgb_t WHITE = '{4'hF, 4'hF, 4'hF};
    localparam rgb_t GREEN = '{4'h0, 4'hF, 4'h0};
    localparam rgb_t RED   = '{4'hF, 4'h0, 4'h0};
    localparam rgb_t GREY  = '{4'h8, 4'h8, 4'h8};
    localparam rgb_t BLACK = '{4'h0, 4'h0, 4'h0};

    // pos in [start, start+size) evaluated with one extra bit so an object
    // near coordinate 1023 extends off-screen instead of wrapping to 0.
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] start,
                                     input int                 size);
        logic [COORD_W:0] p;
        logic [COORD_W:0] lo;
        logic [COORD_W:0] hi;
        p  = {1'b0, pos};
        lo = {1'b0, start};
        hi = lo + (COORD_W+1)'(size);
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/pong_vga_renderer_if.sv
// pong_vga_renderer_if
//   Bundle between the game state machine (master) and the renderer (slave).
//   master drives: pix_en, ball_x, ball_y, paddle1, paddle2, game_over
//   slave drives : hsync, vsync, vga_r, vga_g, vga_b, active, frame_tick
interface pong_vga_renderer_if;
    import pong_pkg::*;

    logic               pix_en;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [COORD_W-1:0] paddle1;
    logic [COORD_W-1:0] paddle2;
    logic               game_over;

    logic               hsync;
    logic               vsync;
    logic [COLOR_W-1:0] vga_r;
    logic [COLOR_W-1:0] vga_g;
    logic [COLOR_W-1:0] vga_b;
    logic               active;
    logic               frame_tick;

    modport master (
        output pix_en, ball_x, ball_y, paddle1, paddle2, game_over,
        input  hsync, vsync, vga_r, vga_g, vga_b, active, frame_tick
    );

    modport slave (
        input  pix_en, ball_x, ball_y, paddle1, paddle2, game_over,
        output hsync, vsync, vga_r, vga_g, vga_b, active, frame_tick
    );

endinterface

// File: rtl/pong_vga_renderer_vga_timing.sv
// vga_timing
//   Horizontal/vertical pixel counters plus registered syncs and active flag.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     pix_en      pixel strobe; every register holds while low
//     hcount      current (pre-increment) column, 0..H_TOTAL-1
//     vcount      current (pre-increment) line,   0..V_TOTAL-1
//     visible     combinational: (hcount, vcount) lies in the active area
//     frame_end   combinational: strobe on the last pixel of the last
//                 visible line, i.e. the moment vertical blanking begins
//     hsync/vsync registered active-low syncs (one pixel of latency)
//     active      registered copy of visible, aligned with syncs
module vga_timing
    import pong_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    output logic [COORD_W-1:0] hcount,
    output logic [COORD_W-1:0] vcount,
    output logic               visible,
    output logic               frame_end,
    output logic               hsync,
    output logic               vsync,
    output logic               active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS      = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS      = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] V_LAST_VIS = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_START   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END     = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END     = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] hcount_reg;
    logic [COORD_W-1:0] vcount_reg;
    logic               hsync_reg;
    logic               vsync_reg;
    logic               active_reg;

    logic h_last;
    logic v_last;
    logic hsync_next;
    logic vsync_next;

    assign h_last     = (hcount_reg == H_LAST);
    assign v_last     = (vcount_reg == V_LAST);
    assign visible    = (hcount_reg < H_VIS) && (vcount_reg < V_VIS);
    assign hsync_next = !((hcount_reg >= HS_START) && (hcount_reg < HS_END));
    assign vsync_next = !((vcount_reg >= VS_START) && (vcount_reg < VS_END));
    assign frame_end  = pix_en && h_last && (vcount_reg == V_LAST_VIS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_reg <= '0;
            vcount_reg <= '0;
            hsync_reg  <= 1'b1;
            vsync_reg  <= 1'b1;
            active_reg <= 1'b0;
        end else if (pix_en) begin
            hcount_reg <= h_last ? '0 : hcount_reg + 1'b1;
            if (h_last) begin
                vcount_reg <= v_last ? '0 : vcount_reg + 1'b1;
            end
            // Outputs describe the pixel addressed before this increment.
            hsync_reg  <= hsync_next;
            vsync_reg  <= vsync_next;
            active_reg <= visible;
        end
    end

    assign hcount = hcount_reg;
    assign vcount = vcount_reg;
    assign hsync  = hsync_reg;
    assign vsync  = vsync_reg;
    assign active = active_reg;

endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer
//   Draws ball, two paddles and background onto a 12-bit RGB VGA stream.
//   Game coordinates are captured into shadow registers once per frame, on
//   the last pixel of the last visible line, so a frame never tears; the
//   same strobe produces frame_tick for the physics engine.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     vga       pong_vga_renderer_if.slave: pix_en and game state in,
//               hsync/vsync/vga_r/vga_g/vga_b/active/frame_tick out
//   Build option:
//     PONG_CENTER_LINE_EN  when defined, draws a dashed grey net in columns
//                          318..321 (16 lines on, 16 off) below the paddles.
module pong_vga_renderer
    import pong_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_ACTIVE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_ACTIVE  = VGA_V_ACTIVE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int BALL_SIZE = 8,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 64,
    parameter int PAD1_X    = 16,
    parameter int PAD2_X    = 616
) (
    input  logic               clk,
    input  logic               rst,
    pong_vga_renderer_if.slave vga
);

    localparam int NUM_PADS = 2;

    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               visible;
    logic               frame_end;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (vga.pix_en),
        .hcount    (hcount),
        .vcount    (vcount),
        .visible   (visible),
        .frame_end (frame_end),
        .hsync     (vga.hsync),
        .vsync     (vga.vsync),
        .active    (vga.active)
    );

    // ------------------------------------------------------------------
    // Shadow registers for ball and game_over, plus the frame tick
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] ball_x_reg;
    logic [COORD_W-1:0] ball_y_reg;
    logic               game_over_reg;
    logic               frame_tick_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ball_x_reg     <= '0;
            ball_y_reg     <= '0;
            game_over_reg  <= 1'b0;
            frame_tick_reg <= 1'b0;
        end else begin
            // Cleared on every clk so the tick is exactly one cycle wide.
            frame_tick_reg <= frame_end;
            if (frame_end) begin
                ball_x_reg    <= vga.ball_x;
                ball_y_reg    <= vga.ball_y;
                game_over_reg <= vga.game_over;
            end
        end
    end

    // ------------------------------------------------------------------
    // Paddles: one shadow register and hit test per paddle
    // ------------------------------------------------------------------
    logic [COORD_W-1:0]  paddle_in [NUM_PADS];
    logic [NUM_PADS-1:0] pad_hit;

    assign paddle_in[0] = vga.paddle1;
    assign paddle_in[1] = vga.paddle2;

    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            localparam int PAD_X = (gi == 0) ? PAD1_X : PAD2_X;

            logic [COORD_W-1:0] paddle_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    paddle_reg <= '0;
                end else if (frame_end) begin
                    paddle_reg <= paddle_in[gi];
                end
            end

            assign pad_hit[gi] = in_span(hcount, COORD_W'(PAD_X), PAD_W) &&
                                 in_span(vcount, paddle_reg, PAD_H);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Compositor
    // ------------------------------------------------------------------
    logic ball_hit;

    assign ball_hit = in_span(hcount, ball_x_reg, BALL_SIZE) &&
                      in_span(vcount, ball_y_reg, BALL_SIZE);

`ifdef PONG_CENTER_LINE_EN
    logic net_hit;

    // vcount[4] alternates every 16 lines, giving the dashed pattern.
    assign net_hit = (hcount >= COORD_W'(NET_X_START)) &&
                     (hcount <  COORD_W'(NET_X_END))   &&
                     !vcount[4];
`endif

    rgb_t pixel_next;
    rgb_t pixel_reg;

    always_comb begin
        pixel_next = BLACK;
        if (visible) begin
            if (ball_hit) begin
                pixel_next = WHITE;
            end else if (|pad_hit) begin
                pixel_next = game_over_reg ? RED : GREEN;
            end
`ifdef PONG_CENTER_LINE_EN
            else if (net_hit) begin
                pixel_next = GREY;
            end
`endif
        end
    end

    // Registered on the same strobe as the syncs so colour and sync align.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_reg <= BLACK;
        end else if (vga.pix_en) begin
            pixel_reg <= pixel_next;
        end
    end

    assign vga.vga_r      = pixel_reg.r;
    assign vga.vga_g      = pixel_reg.g;
    assign vga.vga_b      = pixel_reg.b;
    assign vga.frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer
//   Scoreboard bench for pong_vga_renderer. The driver issues random pixel
//   strobes and random game inputs, forcing chosen game states at the frame
//   latch moments. For each strobe it computes the expected outputs from the
//   pixel index (h = n mod 800, v = n div 800 mod V_TOTAL) and a model of the
//   latched game state, and queues them; the monitor pops and compares after
//   each clock edge. Vertical active height and blanking are shortened via
//   parameters so several complete frames fit in a short run; horizontal
//   timing stays at 640x480 values. Selected pixels are also kept and
//   compared against hand-derived colours at the end.
`timescale 1ns/1ps
module tb_pong_vga_renderer;
    import pong_pkg::*;

    localparam int HA    = 640;
    localparam int HT    = 800;
    localparam int HS0   = 656;
    localparam int HS1   = 752;
    localparam int VA    = 20;
    localparam int VFP   = 2;
    localparam int VSY   = 2;
    localparam int VBP   = 2;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
`ifdef PONG_CENTER_LINE_EN
    localparam bit NET_ON = 1'b1;
`else
    localparam bit NET_ON = 1'b0;
`endif
    localparam logic [15:0] RESET_WORD = 16'hC000;

    typedef struct { int bx; int by; int p1; int p2; int go; } gstate_t;
    typedef struct { int h; int v; int f; logic [15:0] word; } exp_t;
    typedef struct { int f; int x; int y; logic [11:0] want; logic [11:0] got; } probe_t;

    logic clk;
    logic rst;
    pong_vga_renderer_if vif();

    pong_vga_renderer #(
        .V_ACTIVE (VA),
        .V_FP     (VFP),
        .V_SYNC   (VSY),
        .V_BP     (VBP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif.slave)
    );

    always #5 clk = ~clk;

    exp_t    exp_q[$];
    probe_t  probes[$];
    int      checks;
    int      passes;
    int      n;
    int      latch_cnt;
    gstate_t shadow;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h required %h", name, got, want);
    endfunction

    // Colour of visible pixel (h,v) for latched state s, by priority rules.
    function automatic logic [11:0] ref_pixel(int h, int v, gstate_t s);
        if (h >= HA || v >= VA) return 12'h000;
        if (h >= s.bx && h < s.bx + 8 && v >= s.by && v < s.by + 8) return 12'hFFF;
        if ((h >= 16  && h < 24  && v >= s.p1 && v < s.p1 + 64) ||
            (h >= 616 && h < 624 && v >= s.p2 && v < s.p2 + 64))
            return (s.go != 0) ? 12'hF00 : 12'h0F0;
        if (NET_ON && h >= 318 && h < 322 && (v % 32) < 16) return 12'h888;
        return 12'h000;
    endfunction

    function automatic logic [15:0] out_word();
        return {vif.hsync, vif.vsync, vif.active, vif.frame_tick,
                vif.vga_r, vif.vga_g, vif.vga_b};
    endfunction

    function automatic void add_probe(int f, int x, int y, logic [11:0] want);
        probe_t p;
        p.f = f; p.x = x; p.y = y; p.want = want; p.got = 12'hxxx;
        probes.push_back(p);
    endfunction

    task automatic set_inputs(int bx, int by, int p1, int p2, int go);
        vif.ball_x    = 10'(bx);
        vif.ball_y    = 10'(by);
        vif.paddle1   = 10'(p1);
        vif.paddle2   = 10'(p2);
        vif.game_over = go[0];
    endtask

    task automatic do_reset(int cycles);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        latch_cnt = 0;
        shadow = '{default: 0};
        repeat (cycles) begin
            @(negedge clk);
            vif.pix_en = ~vif.pix_en;
        end
        @(negedge clk);
        rst = 1'b0;
        vif.pix_en = 1'b0;
    endtask

    task automatic drive_cycle();
        int   h;
        int   v;
        bit   latch;
        bit   hs;
        bit   vs;
        bit   act;
        exp_t e;
        @(negedge clk);
        vif.pix_en = ($urandom_range(0, 7) != 0);
        h = n % HT;
        v = (n / HT) % VT;
        latch = (vif.pix_en === 1'b1) && (h == HT - 1) && (v == VA - 1);
        if (latch && latch_cnt == 0)      set_inputs(318, 4, 2, 1000, 1);
        else if (latch && latch_cnt == 1) set_inputs(636, 12, 900, 5, 0);
        else set_inputs($urandom_range(0, 1023), $urandom_range(0, 1023),
                        $urandom_range(0, 1023), $urandom_range(0, 1023),
                        $urandom_range(0, 1));
        if (vif.pix_en === 1'b1) begin
            hs  = !(h >= HS0 && h < HS1);
            vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
            act = (h < HA) && (v < VA);
            e.h = h;
            e.v = v;
            e.f = n / FRAME;
            e.word = {hs, vs, act, latch, ref_pixel(h, v, shadow)};
            exp_q.push_back(e);
            if (latch) begin
                shadow.bx = int'(vif.ball_x);
                shadow.by = int'(vif.ball_y);
                shadow.p1 = int'(vif.paddle1);
                shadow.p2 = int'(vif.paddle2);
                shadow.go = int'(vif.game_over);
                $display("latch %0d at strobe %0d: ball=(%0d,%0d) paddle1=%0d paddle2=%0d game_over=%0d",
                         latch_cnt, n, shadow.bx, shadow.by, shadow.p1, shadow.p2, shadow.go);
                latch_cnt++;
            end
            n++;
        end
    endtask

    // Monitor: compares after every clock edge.
    initial begin
        logic        strobe;
        logic [15:0] last_word;
        exp_t        e;
        last_word = RESET_WORD;
        forever begin
            @(posedge clk);
            strobe = vif.pix_en;
            #1;
            if (rst) begin
                check("reset_state", out_word(), RESET_WORD);
                last_word = RESET_WORD;
            end else if (strobe === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_underflow: got strobe with 0 queued entries required at least 1");
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("pixel(%0d,%0d) frame %0d", e.h, e.v, e.f), out_word(), e.word);
                    last_word = e.word;
                    foreach (probes[i]) begin
                        if (probes[i].f == e.f && probes[i].x == e.h && probes[i].y == e.v)
                            probes[i].got = {vif.vga_r, vif.vga_g, vif.vga_b};
                    end
                end
            end else begin
                check("hold_without_strobe", out_word(), {last_word[15:13], 1'b0, last_word[11:0]});
            end
        end
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        vif.pix_en = 1'b0;
        set_inputs(0, 0, 0, 0, 0);
        checks = 0;
        passes = 0;
        n = 0;
        latch_cnt = 0;
        shadow = '{default: 0};

        // Frame 0: shadows still at reset value (all zero)
        add_probe(0, 0, 0, 12'hFFF);
        add_probe(0, 7, 7, 12'hFFF);
        add_probe(0, 8, 0, 12'h000);
        add_probe(0, 0, 8, 12'h000);
        add_probe(0, 16, 0, 12'h0F0);
        add_probe(0, 616, 0, 12'h0F0);
        // Frame 1: ball (318,4), paddle1 2, paddle2 1000, game_over 1
        add_probe(1, 318, 4, 12'hFFF);
        add_probe(1, 325, 11, 12'hFFF);
        add_probe(1, 326, 4, 12'h000);
        add_probe(1, 325, 3, 12'h000);
        add_probe(1, 320, 4, 12'hFFF);
        add_probe(1, 320, 0, NET_ON ? 12'h888 : 12'h000);
        add_probe(1, 321, 15, NET_ON ? 12'h888 : 12'h000);
        add_probe(1, 320, 16, 12'h000);
        add_probe(1, 16, 2, 12'hF00);
        add_probe(1, 23, 19, 12'hF00);
        add_probe(1, 24, 2, 12'h000);
        add_probe(1, 16, 1, 12'h000);
        add_probe(1, 616, 0, 12'h000);
        // Frame 2: ball (636,12), paddle1 900, paddle2 5, game_over 0
        add_probe(2, 636, 12, 12'hFFF);
        add_probe(2, 639, 19, 12'hFFF);
        add_probe(2, 635, 12, 12'h000);
        add_probe(2, 0, 12, 12'h000);
        add_probe(2, 3, 12, 12'h000);
        add_probe(2, 616, 5, 12'h0F0);
        add_probe(2, 623, 19, 12'h0F0);
        add_probe(2, 616, 4, 12'h000);
        add_probe(2, 624, 5, 12'h000);
        add_probe(2, 16, 2, 12'h000);

        do_reset(6);
        while (n < 1500) drive_cycle();
        // Mid-frame reset: must restart at (0,0) with no partial-frame tick
        do_reset(5);
        while (n < 2 * FRAME + VA * HT) drive_cycle();
        @(negedge clk);
        vif.pix_en = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        foreach (probes[i]) begin
            check($sformatf("probe frame %0d (%0d,%0d)", probes[i].f, probes[i].x, probes[i].y),
                  {20'h0, probes[i].got}, {20'h0, probes[i].want});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
